// File: rtl/me_search_ctrl.sv
// Motion-estimation search sequencer: loads the current macroblock, streams the search window to `me`
// one band at a time and keeps the best band SAD. Define ME_EARLY_TERM_EN to build threshold early termination.
module me_search_ctrl #(
    parameter int MACRO_DIM   = 16,
    parameter int SEARCH_DIM  = 48,
    parameter int RD_LAT      = 1,
    localparam int PORT_WIDTH = MACRO_DIM + 1,
    localparam int NBANDS     = SEARCH_DIM - PORT_WIDTH + 1,
    localparam int CW         = $clog2(MACRO_DIM),
    localparam int SW         = $clog2(SEARCH_DIM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          cur_rd,
    output logic [CW-1:0] cur_col,
    output logic          spr_rd,
    output logic [SW-1:0] spr_row,
    output logic [SW-1:0] spr_col,
    output logic          me_start,
    input  logic          me_ready,
    output logic          me_cur_valid,
    output logic          me_spr_valid,
    input  logic          me_valid,
    input  logic [15:0]   me_min_sad,
    output logic [15:0]   best_sad,
`ifdef ME_EARLY_TERM_EN
    input  logic [15:0]   early_thr,
    output logic          early_term,
`endif
    output logic [SW-1:0] best_vy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CUR,
        WAIT_RDY,
        STREAM,
        WAIT_RES,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     curCol_q, curCol_d;
    logic [SW-1:0]     sprCol_q, sprCol_d;
    logic [SW-1:0]     band_q, band_d;
    logic [15:0]       bestSad_q, bestSad_d;
    logic [SW-1:0]     bestVy_q, bestVy_d;
    logic [15:0]       newBest;
    logic [RD_LAT-1:0] curPipe_q;
    logic [RD_LAT-1:0] sprPipe_q;
`ifdef ME_EARLY_TERM_EN
    logic              earlyTerm_q, earlyTerm_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            curCol_q  <= '0;
            sprCol_q  <= '0;
            band_q    <= '0;
            bestSad_q <= 16'hFFFF;
            bestVy_q  <= '0;
            curPipe_q <= '0;
            sprPipe_q <= '0;
`ifdef ME_EARLY_TERM_EN
            earlyTerm_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            curCol_q     <= curCol_d;
            sprCol_q     <= sprCol_d;
            band_q       <= band_d;
            bestSad_q    <= bestSad_d;
            bestVy_q     <= bestVy_d;
            curPipe_q[0] <= cur_rd;
            sprPipe_q[0] <= spr_rd;
            // Read strobes ride a plain delay line so valid lines up with memory data.
            for (int i = 1; i < RD_LAT; i++) begin
                curPipe_q[i] <= curPipe_q[i-1];
                sprPipe_q[i] <= sprPipe_q[i-1];
            end
`ifdef ME_EARLY_TERM_EN
            earlyTerm_q <= earlyTerm_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        curCol_d  = curCol_q;
        sprCol_d  = sprCol_q;
        band_d    = band_q;
        bestSad_d = bestSad_q;
        bestVy_d  = bestVy_q;
        newBest   = bestSad_q;
        busy      = 1'b0;
        done      = 1'b0;
        cur_rd    = 1'b0;
        spr_rd    = 1'b0;
        me_start  = 1'b0;
`ifdef ME_EARLY_TERM_EN
        earlyTerm_d = earlyTerm_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD_CUR;
                    curCol_d  = '0;
                    band_d    = '0;
                    bestSad_d = 16'hFFFF;
                    bestVy_d  = '0;
`ifdef ME_EARLY_TERM_EN
                    earlyTerm_d = 1'b0;
`endif
                end
            end
            LOAD_CUR: begin
                busy   = 1'b1;
                cur_rd = 1'b1;
                if (curCol_q == CW'(MACRO_DIM - 1)) begin
                    state_d = WAIT_RDY;
                end else begin
                    curCol_d = curCol_q + CW'(1);
                end
            end
            WAIT_RDY: begin
                busy = 1'b1;
                if (me_ready) begin
                    me_start = 1'b1;
                    sprCol_d = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                busy   = 1'b1;
                spr_rd = me_ready;
                if (me_ready) begin
                    if (sprCol_q == SW'(SEARCH_DIM - 1)) begin
                        state_d = WAIT_RES;
                    end else begin
                        sprCol_d = sprCol_q + SW'(1);
                    end
                end
            end
            WAIT_RES: begin
                busy = 1'b1;
                if (me_valid) begin
                    // Strict less-than so a tie keeps the earlier band.
                    if (me_min_sad < bestSad_q) begin
                        newBest   = me_min_sad;
                        bestSad_d = me_min_sad;
                        bestVy_d  = band_q;
                    end
`ifdef ME_EARLY_TERM_EN
                    if (newBest <= early_thr) begin
                        earlyTerm_d = 1'b1;
                        state_d     = DONE;
                    end else
`endif
                    if (band_q == SW'(NBANDS - 1)) begin
                        state_d = DONE;
                    end else begin
                        band_d  = band_q + SW'(1);
                        state_d = WAIT_RDY;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cur_col      = curCol_q;
    assign spr_col      = sprCol_q;
    assign spr_row      = band_q;
    assign best_sad     = bestSad_q;
    assign best_vy      = bestVy_q;
    assign me_cur_valid = curPipe_q[RD_LAT-1];
    assign me_spr_valid = sprPipe_q[RD_LAT-1];
`ifdef ME_EARLY_TERM_EN
    assign early_term   = earlyTerm_q;
`endif

endmodule

// File: tb/tb_me_search_ctrl.sv
// Randomised scoreboard bench for me_search_ctrl: an emulated `me` core answers each band, a reference
// model picks the expected best band, and a negedge monitor checks the read sequence and results.
module tb_me_search_ctrl;

    localparam int MACRO_DIM  = 16;
    localparam int SEARCH_DIM = 48;
    localparam int RD_LAT     = 2;
    localparam int NBANDS     = SEARCH_DIM - MACRO_DIM;
    localparam int CW         = 4;
    localparam int SW         = 6;

    logic          clk = 1'b0;
    logic          rst, start, me_ready, me_valid;
    logic [15:0]   me_min_sad;
    logic          busy, done, cur_rd, spr_rd, me_start, me_cur_valid, me_spr_valid;
    logic [CW-1:0] cur_col;
    logic [SW-1:0] spr_row, spr_col, best_vy;
    logic [15:0]   best_sad;

    typedef struct {
        logic [15:0]   sad;
        logic [SW-1:0] vy;
    } exp_t;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        expQ[$];
    logic [15:0] bandSad[NBANDS];

    bit randStall = 0, spurEn = 0, forcedStall = 0, abortMode = 0;
    bit doneSeen = 0, sawAbort = 0, lastReadSeen = 0, trigStall = 0;
    bit inBand = 0, forcedActive = 0, busyObs = 0, prevBusy = 0;
    int lastReadBand = 0, resBand = 0, resCnt = 0, stallCnt = 0, fStallCnt = 0;
    int curCnt = 0, sprCnt = 0, startCnt = 0, expCur = 0, expCol = 0, expBand = -1;
    bit curHist[$], sprHist[$];

    always #5 clk = ~clk;

    me_search_ctrl #(
        .MACRO_DIM (MACRO_DIM),
        .SEARCH_DIM(SEARCH_DIM),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .cur_rd      (cur_rd),
        .cur_col     (cur_col),
        .spr_rd      (spr_rd),
        .spr_row     (spr_row),
        .spr_col     (spr_col),
        .me_start    (me_start),
        .me_ready    (me_ready),
        .me_cur_valid(me_cur_valid),
        .me_spr_valid(me_spr_valid),
        .me_valid    (me_valid),
        .me_min_sad  (me_min_sad),
        .best_sad    (best_sad),
        .best_vy     (best_vy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: the lowest SAD wins, and only a strictly lower SAD displaces an earlier band.
    function automatic exp_t refModel();
        exp_t r;
        r.sad = 16'hFFFF;
        r.vy  = '0;
        for (int v = 0; v < NBANDS; v++) begin
            if (bandSad[v] < r.sad) begin
                r.sad = bandSad[v];
                r.vy  = SW'(v);
            end
        end
        return r;
    endfunction

    task automatic clearEnv();
        expQ.delete();
        resCnt       = 0;
        stallCnt     = 0;
        fStallCnt    = 0;
        lastReadSeen = 0;
        trigStall    = 0;
        inBand       = 0;
        me_ready     = 1'b1;
    endtask

    // Reset held for two cycles; checks the cleared outputs and the emptied valid pipeline.
    task automatic resetDut(input bit check);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        if (check) begin
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_spr_rd", spr_rd, 0);
            checkOutput("rst_best_sad", best_sad, 16'hFFFF);
            checkOutput("rst_spr_valid", me_spr_valid, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clearEnv();
        @(negedge clk);
        if (check) begin
            checkOutput("rst_spr_valid_lat", me_spr_valid, 0);
            checkOutput("rst_cur_rd", cur_rd, 0);
        end
    endtask

    task automatic applyStimulus(input int kind);
        exp_t e;
        bit   finished, aborted;
        randStall   = (kind >= 3);
        spurEn      = (kind >= 3);
        forcedStall = (kind == 2);
        abortMode   = (kind == 4);
        for (int v = 0; v < NBANDS; v++) begin
            case (kind)
                0:       bandSad[v] = (v == 7) ? 16'd5 : 16'(1000 - 10 * v);
                1:       bandSad[v] = 16'd200;
                default: bandSad[v] = (v > 0 && $urandom_range(0, 3) == 0) ? bandSad[$urandom_range(0, v - 1)]
                                                                          : 16'($urandom_range(0, 400));
            endcase
        end
        e = refModel();
        expQ.push_back(e);
        doneSeen = 0;
        sawAbort = 0;
        finished = 0;
        aborted  = 0;
        @(posedge clk); #1;
        start = 1'b1;
        for (int c = 0; c < 8000 && !finished && !aborted; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (doneSeen) begin
                finished = 1;
            end else if (abortMode && sawAbort) begin
                aborted = 1;
                resetDut(1);
            end else if (kind >= 3 && busyObs && $urandom_range(0, 39) == 0) begin
                start = 1'b1;
            end
        end
        if (aborted) begin
            abortMode = 0;
        end else if (!finished) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL search_timeout: kind %0d got no done, required done within 8000 cycles", kind);
            resetDut(0);
        end else begin
            @(negedge clk);
            checkOutput("best_sad_hold", best_sad, e.sad);
            checkOutput("best_vy_hold", best_vy, e.vy);
            checkOutput("done_single", done, 0);
        end
    endtask

    // Emulated motion-estimation core: back-pressure, band results and the odd spurious strobe.
    initial begin
        me_ready   = 1'b1;
        me_valid   = 1'b0;
        me_min_sad = 16'd0;
        forever begin
            @(posedge clk); #1;
            me_valid   = 1'b0;
            me_min_sad = 16'($urandom);
            if (lastReadSeen) begin
                lastReadSeen = 0;
                resCnt       = $urandom_range(1, 4);
                resBand      = (lastReadBand >= 0 && lastReadBand < NBANDS) ? lastReadBand : 0;
            end
            if (resCnt > 0) begin
                resCnt--;
                if (resCnt == 0) begin
                    me_valid   = 1'b1;
                    me_min_sad = bandSad[resBand];
                end
            end else if (spurEn && inBand && $urandom_range(0, 19) == 0) begin
                me_valid   = 1'b1;
                me_min_sad = 16'd0;
            end
            if (trigStall) begin
                trigStall = 0;
                fStallCnt = 5;
            end
            if (fStallCnt > 0) begin
                me_ready     = 1'b0;
                forcedActive = 1;
                fStallCnt--;
            end else begin
                forcedActive = 0;
                if (stallCnt > 0) begin
                    me_ready = 1'b0;
                    stallCnt--;
                end else if (randStall && $urandom_range(0, 9) == 0) begin
                    me_ready = 1'b0;
                    stallCnt = $urandom_range(0, 4);
                end else begin
                    me_ready = 1'b1;
                end
            end
        end
    end

    // Monitor: read sequencing, valid delay lines, and scoreboard pop on every done.
    initial begin
        for (int i = 0; i < RD_LAT; i++) begin
            curHist.push_back(1'b0);
            sprHist.push_back(1'b0);
        end
        forever begin
            @(negedge clk);
            checkOutput("cur_valid_lat", me_cur_valid, curHist.pop_front());
            checkOutput("spr_valid_lat", me_spr_valid, sprHist.pop_front());
            curHist.push_back(cur_rd);
            sprHist.push_back(spr_rd);
            if (rst) begin
                for (int i = 0; i < RD_LAT; i++) begin
                    curHist[i] = 1'b0;
                    sprHist[i] = 1'b0;
                end
                prevBusy = 0;
                busyObs  = 0;
            end else begin
                if (busy && !prevBusy) begin
                    curCnt   = 0;
                    sprCnt   = 0;
                    startCnt = 0;
                    expCur   = 0;
                    expBand  = -1;
                    expCol   = 0;
                    inBand   = 0;
                end
                if (cur_rd) begin
                    checkOutput("cur_col", cur_col, expCur);
                    expCur++;
                    curCnt++;
                end
                if (me_start) begin
                    startCnt++;
                    expBand++;
                    expCol = 0;
                    inBand = 1;
                end
                if (forcedActive) begin
                    checkOutput("stall_spr_rd", spr_rd, 0);
                    checkOutput("stall_spr_col", spr_col, 20);
                end
                if (spr_rd) begin
                    checkOutput("spr_row", spr_row, expBand);
                    checkOutput("spr_col", spr_col, expCol);
                    if (forcedStall && expBand == 2 && expCol == 19) trigStall = 1;
                    if (abortMode && expBand == 5 && expCol == 20) sawAbort = 1;
                    if (expCol == SEARCH_DIM - 1) begin
                        inBand       = 0;
                        lastReadSeen = 1;
                        lastReadBand = expBand;
                    end
                    expCol++;
                    sprCnt++;
                end
                if (done) begin
                    doneSeen = 1;
                    checkOutput("done_busy", busy, 0);
                    if (expQ.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_done: got done, required no pending search");
                    end else begin
                        exp_t e;
                        e = expQ.pop_front();
                        checkOutput("best_sad", best_sad, e.sad);
                        checkOutput("best_vy", best_vy, e.vy);
                        checkOutput("cur_rd_count", curCnt, MACRO_DIM);
                        checkOutput("spr_rd_count", sprCnt, NBANDS * SEARCH_DIM);
                        checkOutput("me_start_count", startCnt, NBANDS);
                    end
                end
                prevBusy = busy;
                busyObs  = busy;
            end
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_cur_rd", cur_rd, 0);
        checkOutput("reset_spr_rd", spr_rd, 0);
        checkOutput("reset_me_start", me_start, 0);
        checkOutput("reset_cur_col", cur_col, 0);
        checkOutput("reset_spr_col", spr_col, 0);
        checkOutput("reset_spr_row", spr_row, 0);
        checkOutput("reset_best_sad", best_sad, 16'hFFFF);
        checkOutput("reset_best_vy", best_vy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        $display("[TB] nominal search");
        applyStimulus(0);
        $display("[TB] tied SADs");
        applyStimulus(1);
        $display("[TB] forced back-pressure in band 2");
        applyStimulus(2);
        $display("[TB] reset mid-stream in band 5");
        applyStimulus(4);
        for (int r = 0; r < 3; r++) begin
            $display("[TB] random search %0d", r);
            applyStimulus(3);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
